// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment bit order is {dp,g,f,e,d,c,b,a}, all active-high.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One display frame worth of content: shadow and live copies share this.
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational hex-to-seven-segment decoder with decimal point.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] segments
);

  always_comb begin
    segments                = '0;
    segments[SEG_G:SEG_A]   = SEG_TABLE[nibble];
    segments[SEG_DP]        = dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with anti-ghost
// blanking, leading-zero suppression and frame-synchronous updates.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        enable,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_digits,
  input  logic [3:0]  upd_dp,
  input  logic [3:0]  upd_blank,
  input  logic        lz_en,
  output logic [7:0]  seven_seg,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam int SHOW_CYC = CLK_DIV - BLANK_CYC;
  localparam int CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam state_t FIRST_STATE = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

  // Assert asynchronously, release two edges after wb_rst_ni rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t           state, state_next;
  logic [1:0]       idx, idx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  disp_t            shadow, display, disp_next;
  logic             pending;
  logic             blank_end, show_end, wrap, idle_exit, boundary, accept;

  assign blank_end = (state == ST_BLANK) && (cnt == BLANK_LAST);
  assign show_end  = (state == ST_SHOW)  && (cnt == SHOW_LAST);
  assign wrap      = enable && show_end && (idx == 2'd3);
  assign idle_exit = enable && (state == ST_IDLE);
  assign boundary  = wrap || idle_exit;
  assign accept    = upd_valid && !pending;
  assign upd_ready = !pending;
  assign disp_next = boundary ? shadow : display;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults first in every always_comb so no path can infer a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt + 1'b1;
    if (!enable) begin
      state_next = ST_IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = FIRST_STATE;
          idx_next   = '0;
          cnt_next   = '0;
        end
        ST_BLANK: if (blank_end) begin
          state_next = ST_SHOW;
          cnt_next   = '0;
        end
        ST_SHOW: if (show_end) begin
          state_next = FIRST_STATE;
          idx_next   = idx + 2'd1;
          cnt_next   = '0;
        end
        default: begin
          state_next = ST_IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else begin
      if (accept)   shadow  <= '{digits: upd_digits, dp: upd_dp, blank: upd_blank};
      if (boundary) display <= shadow;
      pending <= accept || (pending && !boundary);
    end
  end

  // Output values are computed for the upcoming slot and latched only at
  // slot start, so lz_en and content stay frozen for the whole slot.
  logic [3:0] digit_zero;
  logic       hide, slot_start, fd_next;
  logic [7:0] dec_seg, seg_next;
  logic [3:0] en_next;

  seg_decode u_decode (
    .nibble   (disp_next.digits[{idx_next, 2'b00} +: 4]),
    .dp       (disp_next.dp[idx_next]),
    .segments (dec_seg)
  );

  always_comb begin
    digit_zero = '0;
    for (int i = 0; i < 4; i++) digit_zero[i] = (disp_next.digits[4*i +: 4] == 4'h0);
    hide = disp_next.blank[idx_next] ||
           (lz_en && (idx_next != 2'd0) && (&(digit_zero | ~(4'b1111 << idx_next))));
    slot_start = (state_next == ST_SHOW) && ((state != ST_SHOW) || show_end);
    seg_next   = seven_seg;
    en_next    = digit_en;
    fd_next    = wrap;
    if (state_next != ST_SHOW) begin
      seg_next = '0;
      en_next  = '0;
    end else if (slot_start) begin
      seg_next = hide ? 8'h00 : dec_seg;
      en_next  = hide ? 4'h0  : (4'b0001 << idx_next);
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      seven_seg  <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      seven_seg  <= seg_next;
      digit_en   <= en_next;
      frame_done <= fd_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with CLK_DIV=10, BLANK_CYC=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_digits = '0;
  logic [3:0]  upd_dp = '0;
  logic [3:0]  upd_blank = '0;
  logic        lz_en = 1'b0;
  logic [7:0]  seven_seg;
  logic [3:0]  digit_en;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(10), .BLANK_CYC(2)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .enable     (enable),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_digits (upd_digits),
    .upd_dp     (upd_dp),
    .upd_blank  (upd_blank),
    .lz_en      (lz_en),
    .seven_seg  (seven_seg),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one 10-cycle slot from its first cycle: 2 blank, 8 showing.
  task automatic run_slot(input string tag, input logic [3:0] en, input logic [7:0] seg,
                          input logic fd);
    for (int i = 0; i < 10; i++) begin
      check({tag, "_en"},  16'(digit_en),   16'((i < 2) ? 4'h0 : en));
      check({tag, "_seg"}, 16'(seven_seg),  16'((i < 2) ? 8'h00 : seg));
      check({tag, "_fd"},  16'(frame_done), 16'((i == 0) ? fd : 1'b0));
      step();
      if (i == 0) upd_valid = 1'b0;
    end
  endtask

  logic seen;

  initial begin
    #2;
    check("rst_seg", 16'(seven_seg), 16'h0);
    check("rst_en", 16'(digit_en), 16'h0);
    check("rst_fd", 16'(frame_done), 16'h0);
    check("rst_ready", 16'(upd_ready), 16'h1);
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();

    // Load 0x1234 while idle, then start scanning.
    upd_digits = 16'h1234; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    check("load_pending", 16'(upd_ready), 16'h0);
    enable = 1'b1;
    step();
    check("exit_ready", 16'(upd_ready), 16'h1);
    run_slot("f1s0", 4'b0001, 8'h66, 1'b0);
    run_slot("f1s1", 4'b0010, 8'h4F, 1'b0);
    run_slot("f1s2", 4'b0100, 8'h5B, 1'b0);
    run_slot("f1s3", 4'b1000, 8'h06, 1'b0);

    // Mid-frame update: old value stays for the rest of this frame.
    run_slot("f2s0", 4'b0001, 8'h66, 1'b1);
    upd_digits = 16'hABCD; upd_valid = 1'b1;
    check("mid_ready_before", 16'(upd_ready), 16'h1);
    run_slot("f2s1", 4'b0010, 8'h4F, 1'b0);
    check("mid_ready_held", 16'(upd_ready), 16'h0);
    run_slot("f2s2", 4'b0100, 8'h5B, 1'b0);
    run_slot("f2s3", 4'b1000, 8'h06, 1'b0);
    check("bnd_ready", 16'(upd_ready), 16'h1);
    run_slot("f3s0", 4'b0001, 8'h5E, 1'b1);
    run_slot("f3s1", 4'b0010, 8'h39, 1'b0);
    run_slot("f3s2", 4'b0100, 8'h7C, 1'b0);
    run_slot("f3s3", 4'b1000, 8'h77, 1'b0);

    // Drop enable in the middle of slot 2.
    run_slot("f4s0", 4'b0001, 8'h5E, 1'b1);
    run_slot("f4s1", 4'b0010, 8'h39, 1'b0);
    repeat (4) step();
    check("drop_pre_en", 16'(digit_en), 16'h4);
    check("drop_pre_seg", 16'(seven_seg), 16'h7C);
    enable = 1'b0;
    step();
    check("drop_en", 16'(digit_en), 16'h0);
    check("drop_seg", 16'(seven_seg), 16'h0);
    check("drop_fd", 16'(frame_done), 16'h0);
    seen = 1'b0;
    repeat (50) begin
      step();
      if (frame_done || digit_en != 4'h0 || seven_seg != 8'h00) seen = 1'b1;
    end
    check("idle_quiet", 16'(seen), 16'h0);

    // Leading-zero suppression on 0x0050, restarting from digit0 blank.
    upd_digits = 16'h0050; lz_en = 1'b1; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    enable = 1'b1;
    step();
    run_slot("lz1s0", 4'b0001, 8'h3F, 1'b0);
    run_slot("lz1s1", 4'b0010, 8'h6D, 1'b0);
    run_slot("lz1s2", 4'b0000, 8'h00, 1'b0);
    run_slot("lz1s3", 4'b0000, 8'h00, 1'b0);

    // lz off; queue dp on digit0 and force-blank on digit2 for next frame.
    lz_en = 1'b0;
    upd_dp = 4'b0001; upd_blank = 4'b0100; upd_valid = 1'b1;
    run_slot("lz0s0", 4'b0001, 8'h3F, 1'b1);
    run_slot("lz0s1", 4'b0010, 8'h6D, 1'b0);
    run_slot("lz0s2", 4'b0100, 8'h3F, 1'b0);
    run_slot("lz0s3", 4'b1000, 8'h3F, 1'b0);
    run_slot("dps0", 4'b0001, 8'hBF, 1'b1);
    run_slot("dps1", 4'b0010, 8'h6D, 1'b0);
    run_slot("dps2", 4'b0000, 8'h00, 1'b0);
    run_slot("dps3", 4'b1000, 8'h3F, 1'b0);

    // Reset asserted mid-SHOW with an update pending.
    upd_digits = 16'h1234; upd_dp = '0; upd_blank = '0; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    repeat (3) step();
    check("pre_rst_ready", 16'(upd_ready), 16'h0);
    check("pre_rst_en", 16'(digit_en), 16'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_seg", 16'(seven_seg), 16'h0);
    check("mid_rst_en", 16'(digit_en), 16'h0);
    check("mid_rst_fd", 16'(frame_done), 16'h0);
    check("mid_rst_ready", 16'(upd_ready), 16'h1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000: clock cycles per digit slot; legal range CLK_DIV > BLANK_CYC.
REQ-002 SHALL have parameter BLANK_CYC, default 8: anti-ghost cycles at the start of each slot; 0 is legal.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port wb_clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port wb_rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  scan run; low forces IDLE.
REQ-007 SHALL have port upd_valid  input  1  update request.
REQ-008 SHALL have port upd_ready  output  1  update accept; transfer occurs when upd_valid && upd_ready.
REQ-009 SHALL have port upd_digits  input  16  four hex nibbles; digit0 = [3:0], digit3 = [15:12].
REQ-010 SHALL have port upd_dp  input  4  per-digit decimal point.
REQ-011 SHALL have port upd_blank  input  4  per-digit force-blank.
REQ-012 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-013 SHALL have port seven_seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-high, registered.
REQ-014 SHALL have port digit_en  output  4  one-hot digit select, active-high, registered.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse at frame end, registered.

Function
REQ-016 SHALL implement FSM states IDLE, BLANK and SHOW, plus a 2-bit digit index and a slot counter.
REQ-017 SHALL behave as follows in IDLE: seven_seg=0, digit_en=0, index=0; enable=1 moves to BLANK, or to SHOW if BLANK_CYC=0.
REQ-018 SHALL behave as follows in BLANK: digit_en=0 and seven_seg=0 for BLANK_CYC cycles, then move to SHOW.
REQ-019 SHALL behave as follows in SHOW: digit_en=1<<index and seven_seg=decode(index) for CLK_DIV-BLANK_CYC cycles, then increment index mod 4 and move to BLANK (or SHOW if BLANK_CYC=0).
REQ-020 SHALL pulse frame_done for exactly one cycle on the cycle after the index wraps 3->0; one frame = 4*CLK_DIV cycles.
REQ-021 SHALL decode as hex 0-F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71, with seven_seg[7] = dp bit.
REQ-022 SHALL drive digit_en=0 and seven_seg=0 for the whole SHOW slot of a digit with its blank bit set.
REQ-023 SHALL, when lz_en=1, suppress a digit exactly like blank if it is zero and all higher digits are zero or suppressed; digit0 is never suppressed.
REQ-024 SHALL load an accepted update into a shadow register and set a pending flag; upd_ready = !pending.
REQ-025 SHALL copy shadow to display registers and clear pending at every frame boundary (index wrap) and on IDLE exit.
REQ-026 SHALL hold an update accepted on a boundary cycle until the next boundary.
REQ-027 SHALL, on enable falling mid-slot, enter IDLE on the next cycle with index and counter cleared and pending/shadow retained; frame_done is not pulsed.
REQ-028 SHALL sample lz_en continuously; it takes effect at the next slot start.

Reset
REQ-029 SHALL, on wb_rst_ni low, asynchronously force state=IDLE, index=0, counter=0, pending=0, shadow and display registers=0, seven_seg=0, digit_en=0, frame_done=0, upd_ready=1.
REQ-030 SHALL release reset synchronously to wb_clk_i; the first state change occurs no earlier than the second rising edge after deassertion.

Structure
REQ-031 SHALL place the state enum, the 16-entry segment table and the segment bit-position constants in shared package seg_pkg.
REQ-032 SHALL implement decoding in combinational sub-module seg_decode (nibble, dp -> 8-bit segments), instantiated once.

Verification (CLK_DIV=10, BLANK_CYC=2)
REQ-033 SHALL cover: reset asserted mid-SHOW -> all outputs 0 in the same cycle and upd_ready=1.
REQ-034 SHALL cover: load 0x1234 then enable=1 -> 2 cycles digit_en=0, 8 cycles 0001/0x66, then 0010/0x4F, 0100/0x5B, 1000/0x06, with frame_done every 40 cycles.
REQ-035 SHALL cover: 0x0050 with lz_en=1 -> slots 2 and 3 digit_en=0, slot 1 0x6D, slot 0 0x3F; with lz_en=0 slots 2 and 3 show 0x3F.
REQ-036 SHALL cover: update 0xABCD accepted mid-frame -> upd_ready=0 until the boundary, old value shown through slot 3, new value 0x5E shown on slot 0 of the next frame.
REQ-037 SHALL cover: upd_dp=0001 with upd_blank=0100 -> slot 0 seven_seg[7]=1, slot 2 digit_en=0.
REQ-038 SHALL cover: enable dropped in slot 2 -> IDLE next cycle, no frame_done pulse; re-enable -> restart at digit0 BLANK.
